// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory/I-O bus controller.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned CNT_W         = 4;
    localparam int unsigned OFF_GPIO_OUT  = 0;
    localparam int unsigned OFF_GPIO_IN   = 2;
    localparam int unsigned OFF_TIMER     = 4;
    localparam int unsigned OFF_TIMER_CMP = 6;

endpackage

// File: rtl/mem_bus_io.sv
// Memory-mapped I/O register file: GPIO output/input and, with MEM_BUS_TIMER_EN,
// a free-running timer with compare interrupt.
module mem_bus_io
    import mem_bus_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [N-1:0] off,
    input  logic [N-1:0] wdata,
    input  logic [N-1:0] gpio_in,
    output logic [N-1:0] rd_data_c,
    output logic [N-1:0] gpio_out,
    output logic         irq
);

`ifdef MEM_BUS_TIMER_EN
    logic [N-1:0] timer;
    logic [N-1:0] timer_cmp;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out <= '0;
        end else if (wr_en && (off == N'(OFF_GPIO_OUT))) begin
            gpio_out <= wdata;
        end
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        rd_data_c = '0;
        if (off == N'(OFF_GPIO_OUT)) begin
            rd_data_c = gpio_out;
        end else if (off == N'(OFF_GPIO_IN)) begin
            rd_data_c = gpio_in;
        end
`ifdef MEM_BUS_TIMER_EN
        else if (off == N'(OFF_TIMER)) begin
            rd_data_c = timer;
        end else if (off == N'(OFF_TIMER_CMP)) begin
            rd_data_c = timer_cmp;
        end
`endif
    end

`ifdef MEM_BUS_TIMER_EN
    // A compare write clears irq and takes priority over a same-edge match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            timer_cmp <= '0;
            irq       <= 1'b0;
        end else begin
            timer <= timer + N'(1);
            if (wr_en && (off == N'(OFF_TIMER_CMP))) begin
                timer_cmp <= wdata;
                irq       <= 1'b0;
            end else if (timer == timer_cmp) begin
                irq <= 1'b1;
            end
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU bus controller: routes accesses to wait-stated data memory or to I/O registers.
// Timer registers and irq are present only when MEM_BUS_TIMER_EN is defined.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int unsigned  N           = 16,
    parameter int unsigned  WAIT_STATES = 2,
    parameter logic [N-1:0] IO_BASE     = N'(16'hFF00)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         we,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         ready,
    output logic         err,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic [N-1:0] gpio_in,
    output logic [N-1:0] gpio_out,
    output logic         irq
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             we_q;
    logic             we_d;
    logic [N-1:0]     addr_d;
    logic [N-1:0]     wdata_d;
    logic [N-1:0]     rdata_d;
    logic             ready_d;
    logic             err_d;
    logic             mem_we_d;
    logic             is_io_c;
    logic             io_wr_c;
    logic [N-1:0]     io_off_c;
    logic [N-1:0]     io_rdata_c;

    assign is_io_c  = (addr >= IO_BASE);
    assign io_off_c = addr - IO_BASE;

    mem_bus_io #(.N(N)) u_io (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (io_wr_c),
        .off       (io_off_c),
        .wdata     (wdata),
        .gpio_in   (gpio_in),
        .rd_data_c (io_rdata_c),
        .gpio_out  (gpio_out),
        .irq       (irq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            rdata     <= rdata_d;
            ready     <= ready_d;
            err       <= err_d;
            mem_we    <= mem_we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    // I/O and misaligned accesses finish on the accept edge; memory waits out the counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        rdata_d  = '0;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        mem_we_d = 1'b0;
        io_wr_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (addr[0]) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (is_io_c) begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        io_wr_c = we;
                        rdata_d = we ? '0 : io_rdata_c;
                    end else begin
                        state_d  = WAIT;
                        cnt_d    = CNT_W'(WAIT_STATES - 1);
                        mem_we_d = we && (WAIT_STATES == 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = we_q ? '0 : mem_rdata;
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    mem_we_d = we_q && (cnt_q == CNT_W'(1));
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter N, default 16: data and address width in bits.
REQ-002 Parameter WAIT_STATES, default 2, legal range 1..15: data-memory access wait cycles.
REQ-003 Parameter IO_BASE, default 16'hFF00: addresses at or above this value decode to memory-mapped I/O; all lower addresses decode to data memory.
REQ-004 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1: system clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port req, input, 1: CPU access request.
REQ-008 Port we, input, 1: 1 = write, 0 = read.
REQ-009 Port addr, input, N: CPU byte address.
REQ-010 Port wdata, input, N: CPU write data.
REQ-011 Port rdata, output, N: read data; valid while ready=1.
REQ-012 Port ready, output, 1: one-cycle access-complete strobe.
REQ-013 Port err, output, 1: misaligned-access flag; valid while ready=1.
REQ-014 Port mem_we, output, 1: data-memory write strobe.
REQ-015 Port mem_addr, output, N: data-memory address.
REQ-016 Port mem_wdata, output, N: data-memory write data.
REQ-017 Port mem_rdata, input, N: data-memory combinational read data.
REQ-018 Port gpio_in, input, N: external input pins.
REQ-019 Port gpio_out, output, N: output register.
REQ-020 Port irq, output, 1: timer-match interrupt; sticky.

Function
REQ-021 The controller SHALL implement a finite-state machine with three states: IDLE, WAIT, RESP.
REQ-022 In IDLE, req=1 SHALL latch addr, we and wdata at the clock edge; this edge is the accept edge.
REQ-023 From IDLE, a data-memory address SHALL go to WAIT; an I/O address or a misaligned address (addr[0]=1) SHALL go directly to RESP.
REQ-024 WAIT SHALL last exactly WAIT_STATES cycles, using a 4-bit down-counter; the last WAIT cycle SHALL assert mem_we for a write and capture mem_rdata into rdata for a read.
REQ-025 ready SHALL be high for exactly one cycle in RESP, then the FSM SHALL return to IDLE.
REQ-026 Latency SHALL be WAIT_STATES+1 edges from accept to ready for memory accesses, and 1 edge for I/O or misaligned accesses.
REQ-027 req SHALL be ignored in WAIT and RESP; back-to-back requests SHALL be accepted no earlier than the edge that leaves RESP.
REQ-028 mem_addr and mem_wdata SHALL come from the latched registers and stay stable for the whole of WAIT.
REQ-029 mem_we SHALL never assert outside the final WAIT cycle.
REQ-030 A misaligned access SHALL set err=1 with ready, perform no write, and return rdata=0.
REQ-031 The I/O map SHALL be:
  - IO_BASE+0: GPIO_OUT, read/write.
  - IO_BASE+2: GPIO_IN, read-only; writes are ignored.
  - Other I/O offsets: read 0; writes are ignored.
REQ-032 I/O writes SHALL update the target register at the edge that enters RESP.

Reset
REQ-033 Asserting reset SHALL force, asynchronously: FSM=IDLE, counter=0, rdata=0, ready=0, err=0, mem_we=0, mem_addr=0, mem_wdata=0, gpio_out=0, irq=0, timer registers=0.
REQ-034 Reset asserted mid-access SHALL abort the access with no write and no ready pulse.

Configuration
REQ-035 Macro MEM_BUS_TIMER_EN, when defined, SHALL add the timer registers:
  - IO_BASE+4: TIMER, a read-only free-running N-bit counter that wraps to 0.
  - IO_BASE+6: TIMER_CMP, read/write.
  - irq SHALL set on the edge where TIMER==TIMER_CMP.
  - Any write to TIMER_CMP SHALL clear irq; if the set and the clear coincide, the clear SHALL win.
REQ-036 When MEM_BUS_TIMER_EN is undefined, irq SHALL be tied to 0, and offsets +4 and +6 SHALL behave as unmapped.

Structure
REQ-037 The shared package mem_bus_pkg SHALL hold:
  - the state enum (IDLE, WAIT, RESP);
  - I/O offset constants (OFF_GPIO_OUT=0, OFF_GPIO_IN=2, OFF_TIMER=4, OFF_TIMER_CMP=6).
REQ-038 A single sub-module, mem_bus_io, SHALL contain the I/O register file and the timer.

Verification
REQ-039 Test: write 16'h1234 to 16'h0010 with WAIT_STATES=2. Required: mem_we high for exactly 1 cycle at edge 2; ready at edge 3; err=0.
REQ-040 Test: read 16'h0010 with mem_rdata=16'hBEEF. Required: rdata=16'hBEEF with ready at edge 3.
REQ-041 Test: write 16'h00A5 to IO_BASE+0, then read IO_BASE+2 with gpio_in=16'h5A5A. Required: gpio_out=16'h00A5 after 1 edge; the read returns 16'h5A5A after 1 edge.
REQ-042 Test: access address 16'h0011. Required: ready and err together after 1 edge; mem_we stays 0.
REQ-043 Test: assert reset during the first WAIT cycle of a write. Required: no mem_we, no ready, all outputs 0.
REQ-044 Test (MEM_BUS_TIMER_EN defined): set TIMER_CMP=16'd20. Required: irq rises at the match and holds; a write to TIMER_CMP clears it. With the macro undefined, irq stays 0.
